free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PRW, default 6, physical register index width; NPREG = 2**PRW entries.
REQ-002 SHALL have parameter NARCH, default 16, count of physical registers architecturally mapped at reset (p0..pNARCH-1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port alloc_en  input  2  rename consumes head entries; bit0 = oldest.
REQ-006 SHALL have port alloc_rdy  output  2  bit0: free_cnt>=1; bit1: free_cnt>=2.
REQ-007 SHALL have port alloc_preg  output  2xPRW  [0] = entry at head, [1] = entry at head+1 (combinational peek of stored entries).
REQ-008 SHALL have port rel_en  input  2  ROB retire/rollback release valid, independent bits.
REQ-009 SHALL have port rel_preg  input  2xPRW  register returned per port.
REQ-010 SHALL have port free_cnt  output  PRW+1  number of free entries.
REQ-011 SHALL have port err  output  3  sticky: [0] alloc underflow, [1] release overflow, [2] double free.

Function
REQ-012 SHALL store entries in an NPREG-deep circular queue with head (pop) and tail (push) pointers, PRW bits each, wrapping modulo NPREG.
REQ-013 SHALL keep a NPREG-bit free_map; bit set iff that register is in the queue.
REQ-014 alloc_en legal encodings: 00, 01, 11; pop count = popcount(alloc_en); pop consumes head then head+1; head advances by pop count.
REQ-015 alloc_en bit1 without bit0 SHALL be ignored entirely and set err[0].
REQ-016 pop of N > free_cnt (per alloc_rdy) SHALL pop nothing, leave state unchanged, set err[0].
REQ-017 Popped registers SHALL clear their free_map bit on the same edge.
REQ-018 Release ports accepted independently; accepted releases compacted: single accepted release written at tail; two written at tail (port0) and tail+1 (port1); tail advances by accepted count.
REQ-019 Release SHALL be rejected (dropped, err[2] set) if its free_map bit is already set, or if port1 names the same register as an accepted port0 in the same cycle.
REQ-020 Release SHALL be rejected (dropped, err[1] set) if free_cnt minus this cycle's pops plus prior accepted releases would exceed NPREG; port0 has priority.
REQ-021 Accepted release SHALL set free_map bit on the same edge.
REQ-022 Simultaneous pop and push: free_cnt_next = free_cnt - pops + accepted releases; no same-cycle bypass -- a register released in cycle n is allocatable no earlier than n+1.
REQ-023 Pop of an entry and release of that same register in one cycle SHALL be legal (bit cleared by pop, set by release; net set).
REQ-024 alloc_preg for slots beyond free_cnt is don't-care; alloc_rdy is the sole validity indicator.
REQ-025 All outputs other than alloc_preg SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-026 err bits SHALL remain set until reset.

Reset
REQ-027 On rst assertion, asynchronously: head=0, tail=NPREG-NARCH (mod NPREG), queue entries i=0..NPREG-NARCH-1 hold NARCH+i, free_map bits NARCH..NPREG-1 set, others clear, err=0.
REQ-028 Reset values of outputs: free_cnt=NPREG-NARCH (48 default), alloc_rdy=11, alloc_preg={17,16}, err=000.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight alloc/release of that cycle; first post-reset edge behaves as from REQ-027.

Verification
REQ-030 Reset, then alloc_en=11 once -> alloc_preg was {17,16}; next cycle free_cnt=46, alloc_preg={19,18}.
REQ-031 Drain 48 regs with alloc_en=11 x24 -> free_cnt=0, alloc_rdy=00; alloc_en=01 -> err[0]=1, free_cnt stays 0.
REQ-032 From empty, rel_en=10 rel_preg[1]=5 -> next cycle free_cnt=1, alloc_rdy=01, alloc_preg[0]=5; same-cycle alloc not satisfied.
REQ-033 rel_en=11 with rel_preg={7,7} where 7 allocated -> only port0 accepted, free_cnt+1, err[2]=1; later release of 20 while 20 still free -> dropped, err[2] held.
REQ-034 Run >NPREG alloc/release cycles at free_cnt=1 with alloc_en=01 and rel_en=01 every cycle -> pointers wrap past 63, free_cnt constant 1, alloc_preg each cycle equals register released prior cycle.
REQ-035 Assert rst asynchronously mid-cycle with alloc_en=11, rel_en=11 -> outputs return to REQ-028 values immediately, before next clk edge.

Source files
------------

// File: rtl/free_list_if.sv
`default_nettype none
// ============================================================================
// Module   : free_list_if
// Purpose  : Rename/ROB-side bundle for the physical register free list.
// Revision : 1.0 - initial release
// ============================================================================
interface free_list_if #(
    parameter int PRW = 6
);
    logic [1:0]          alloc_en;
    logic [1:0]          alloc_rdy;
    logic [1:0][PRW-1:0] alloc_preg;
    logic [1:0]          rel_en;
    logic [1:0][PRW-1:0] rel_preg;
    logic [PRW:0]        free_cnt;
    logic [2:0]          err;

    modport master (
        output alloc_en, rel_en, rel_preg,
        input  alloc_rdy, alloc_preg, free_cnt, err
    );

    modport slave (
        input  alloc_en, rel_en, rel_preg,
        output alloc_rdy, alloc_preg, free_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular-queue physical register free list, 2 pops + 2 pushes/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
    parameter int PRW   = 6,
    parameter int NARCH = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    free_list_if.slave fl
);
    localparam int               c_NPREG    = 1 << PRW;
    localparam logic [PRW:0]     c_RST_CNT  = (PRW+1)'(c_NPREG - NARCH);
    localparam logic [PRW-1:0]   c_RST_TAIL = PRW'(c_NPREG - NARCH);
    localparam logic [PRW+1:0]   c_CAP      = (PRW+2)'(c_NPREG);

    logic [PRW-1:0]     r_queue [c_NPREG];
    logic [PRW-1:0]     r_head;
    logic [PRW-1:0]     r_tail;
    logic [c_NPREG-1:0] r_free_map;
    logic [PRW:0]       r_free_cnt;
    logic [2:0]         r_err;

    logic               w_alloc_bad;
    logic               w_underflow;
    logic [1:0]         w_pop_req;
    logic [1:0]         w_pop_n;
    logic [1:0]         w_push_n;
    logic [PRW-1:0]     w_head1;
    logic [PRW-1:0]     w_tail1;
    logic [PRW-1:0]     w_wr1_idx;
    logic [c_NPREG-1:0] w_map_pop;
    logic [c_NPREG-1:0] w_map_next;
    logic [PRW+1:0]     w_base;
    logic [PRW:0]       w_cnt_next;
    logic               w_dup0, w_dup1;
    logic               w_ovf0, w_ovf1;
    logic               w_acc0, w_acc1;
    logic [2:0]         w_err_next;

    assign w_head1 = r_head + PRW'(1);
    assign w_tail1 = r_tail + PRW'(1);

    always_comb begin
        w_alloc_bad = (fl.alloc_en == 2'b10);
        w_pop_req   = {1'b0, fl.alloc_en[0]} + {1'b0, fl.alloc_en[1] & fl.alloc_en[0]};
        w_underflow = w_alloc_bad || ((PRW+1)'(w_pop_req) > r_free_cnt);
        w_pop_n     = w_underflow ? 2'd0 : w_pop_req;

        // Duplicate detection uses the map after this cycle's pops, so a
        // register popped and released on the same edge is accepted.
        w_map_pop = r_free_map;
        if (w_pop_n != 2'd0) w_map_pop[r_queue[r_head]]  = 1'b0;
        if (w_pop_n == 2'd2) w_map_pop[r_queue[w_head1]] = 1'b0;

        w_base = (PRW+2)'(r_free_cnt) - (PRW+2)'(w_pop_n);

        w_dup0 = w_map_pop[fl.rel_preg[0]];
        w_ovf0 = (w_base + (PRW+2)'(1)) > c_CAP;
        w_acc0 = fl.rel_en[0] & ~w_dup0 & ~w_ovf0;

        w_dup1 = w_map_pop[fl.rel_preg[1]] | (w_acc0 & (fl.rel_preg[1] == fl.rel_preg[0]));
        w_ovf1 = (w_base + (PRW+2)'(w_acc0) + (PRW+2)'(1)) > c_CAP;
        w_acc1 = fl.rel_en[1] & ~w_dup1 & ~w_ovf1;

        w_map_next = w_map_pop;
        if (w_acc0) w_map_next[fl.rel_preg[0]] = 1'b1;
        if (w_acc1) w_map_next[fl.rel_preg[1]] = 1'b1;

        w_push_n   = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_cnt_next = (PRW+1)'(w_base + (PRW+2)'(w_push_n));
        w_wr1_idx  = w_acc0 ? w_tail1 : r_tail;

        w_err_next = r_err | {
            (fl.rel_en[0] & w_dup0) | (fl.rel_en[1] & w_dup1),
            (fl.rel_en[0] & ~w_dup0 & w_ovf0) | (fl.rel_en[1] & ~w_dup1 & w_ovf1),
            w_underflow
        };
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= c_RST_TAIL;
            r_free_cnt <= c_RST_CNT;
            r_err      <= '0;
            for (int i = 0; i < c_NPREG; i++) begin
                r_free_map[i] <= (i >= NARCH);
                r_queue[i]    <= (i < c_NPREG - NARCH) ? PRW'(NARCH + i) : '0;
            end
        end else begin
            r_head     <= r_head + PRW'(w_pop_n);
            r_tail     <= r_tail + PRW'(w_push_n);
            r_free_cnt <= w_cnt_next;
            r_free_map <= w_map_next;
            r_err      <= w_err_next;
            if (w_acc0) r_queue[r_tail]    <= fl.rel_preg[0];
            if (w_acc1) r_queue[w_wr1_idx] <= fl.rel_preg[1];
        end
    end

    assign fl.alloc_preg[0] = r_queue[r_head];
    assign fl.alloc_preg[1] = r_queue[w_head1];
    assign fl.alloc_rdy     = {r_free_cnt >= (PRW+1)'(2), r_free_cnt != '0};
    assign fl.free_cnt      = r_free_cnt;
    assign fl.err           = r_err;
endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list
// Purpose  : Scoreboard bench for free_list against a behavioural queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list;
    localparam int PRW   = 6;
    localparam int NARCH = 16;
    localparam int NPREG = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    free_list_if #(.PRW(PRW)) fl ();
    free_list #(.PRW(PRW), .NARCH(NARCH)) dut (.clk(clk), .rst(rst), .fl(fl));

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_err    = 0;
    int       mq[$];
    bit       mmap[NPREG];
    logic [2:0] merr;
    int       exp_q[$];
    int       got_q[$];

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < NPREG; i++) mmap[i] = (i >= NARCH);
        for (int i = 0; i < NPREG - NARCH; i++) mq.push_back(NARCH + i);
        merr = 3'b000;
    endtask

    // Drives one cycle; popped entries go to the scoreboard as expected values
    // (from the model) and observed values (DUT peek before the edge).
    task automatic drive_cycle(input logic [1:0] ae, input logic [1:0] re, input int p0, input int p1);
        int npop;
        fl.alloc_en    = ae;
        fl.rel_en      = re;
        fl.rel_preg[0] = PRW'(p0);
        fl.rel_preg[1] = PRW'(p1);
        #1;
        npop = (ae == 2'b01) ? 1 : (ae == 2'b11) ? 2 : 0;
        if (ae == 2'b10) merr[0] = 1'b1;
        if (npop > mq.size()) begin
            merr[0] = 1'b1;
            npop    = 0;
        end
        for (int k = 0; k < npop; k++) begin
            exp_q.push_back(mq[0]);
            got_q.push_back(int'(fl.alloc_preg[k]));
            mmap[mq[0]] = 1'b0;
            void'(mq.pop_front());
        end
        if (re[0]) begin
            if (mmap[p0]) merr[2] = 1'b1;
            else if (mq.size() + 1 > NPREG) merr[1] = 1'b1;
            else begin mq.push_back(p0); mmap[p0] = 1'b1; end
        end
        if (re[1]) begin
            if (mmap[p1]) merr[2] = 1'b1;
            else if (mq.size() + 1 > NPREG) merr[1] = 1'b1;
            else begin mq.push_back(p1); mmap[p1] = 1'b1; end
        end
        @(posedge clk);
        #1;
        fl.alloc_en = 2'b00;
        fl.rel_en   = 2'b00;
    endtask

    task automatic test_reset();
        n_checks++; if (fl.free_cnt !== 7'd48) begin n_err++; $display("FAIL reset_cnt: got %0d expected 48", fl.free_cnt); end
        n_checks++; if (fl.alloc_rdy !== 2'b11) begin n_err++; $display("FAIL reset_rdy: got %b expected 11", fl.alloc_rdy); end
        n_checks++; if (fl.alloc_preg[0] !== 6'd16) begin n_err++; $display("FAIL reset_preg0: got %0d expected 16", fl.alloc_preg[0]); end
        n_checks++; if (fl.alloc_preg[1] !== 6'd17) begin n_err++; $display("FAIL reset_preg1: got %0d expected 17", fl.alloc_preg[1]); end
        n_checks++; if (fl.err !== 3'b000) begin n_err++; $display("FAIL reset_err: got %b expected 000", fl.err); end
    endtask

    task automatic test_alloc_pair();
        drive_cycle(2'b11, 2'b00, 0, 0);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_err++; $display("FAIL pair_sb: got %0d expected %0d", g, e); end
        end
        n_checks++; if (fl.free_cnt !== 7'd46) begin n_err++; $display("FAIL pair_cnt: got %0d expected 46", fl.free_cnt); end
        n_checks++; if (fl.alloc_preg[0] !== 6'd18 || fl.alloc_preg[1] !== 6'd19) begin
            n_err++; $display("FAIL pair_peek: got {%0d,%0d} expected {19,18}", fl.alloc_preg[1], fl.alloc_preg[0]);
        end
    endtask

    task automatic test_drain();
        repeat (23) drive_cycle(2'b11, 2'b00, 0, 0);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_err++; $display("FAIL drain_sb: got %0d expected %0d", g, e); end
        end
        n_checks++; if (fl.free_cnt !== 7'd0) begin n_err++; $display("FAIL drain_cnt: got %0d expected 0", fl.free_cnt); end
        n_checks++; if (fl.alloc_rdy !== 2'b00) begin n_err++; $display("FAIL drain_rdy: got %b expected 00", fl.alloc_rdy); end
        n_checks++; if (fl.err !== 3'b000) begin n_err++; $display("FAIL drain_err: got %b expected 000", fl.err); end
        drive_cycle(2'b01, 2'b00, 0, 0);
        n_checks++; if (fl.err !== 3'b001) begin n_err++; $display("FAIL underflow_err: got %b expected 001", fl.err); end
        n_checks++; if (fl.free_cnt !== 7'd0) begin n_err++; $display("FAIL underflow_cnt: got %0d expected 0", fl.free_cnt); end
    endtask

    task automatic test_release_empty();
        drive_cycle(2'b01, 2'b10, 0, 5);
        n_checks++; if (got_q.size() !== 0) begin n_err++; $display("FAIL empty_pop: got %0d pops expected 0", got_q.size()); end
        n_checks++; if (fl.free_cnt !== 7'd1) begin n_err++; $display("FAIL empty_rel_cnt: got %0d expected 1", fl.free_cnt); end
        n_checks++; if (fl.alloc_rdy !== 2'b01) begin n_err++; $display("FAIL empty_rel_rdy: got %b expected 01", fl.alloc_rdy); end
        n_checks++; if (fl.alloc_preg[0] !== 6'd5) begin n_err++; $display("FAIL empty_rel_peek: got %0d expected 5", fl.alloc_preg[0]); end
        n_checks++; if (fl.err !== merr) begin n_err++; $display("FAIL empty_rel_err: got %b expected %b", fl.err, merr); end
    endtask

    task automatic test_double_free();
        drive_cycle(2'b00, 2'b11, 7, 7);
        n_checks++; if (fl.free_cnt !== 7'd2) begin n_err++; $display("FAIL dup_pair_cnt: got %0d expected 2", fl.free_cnt); end
        n_checks++; if (fl.err !== 3'b101) begin n_err++; $display("FAIL dup_pair_err: got %b expected 101", fl.err); end
        drive_cycle(2'b00, 2'b01, 20, 0);
        drive_cycle(2'b00, 2'b01, 20, 0);
        n_checks++; if (fl.free_cnt !== 7'd3) begin n_err++; $display("FAIL dup_20_cnt: got %0d expected 3", fl.free_cnt); end
        n_checks++; if (fl.err !== merr) begin n_err++; $display("FAIL dup_20_err: got %b expected %b", fl.err, merr); end
    endtask

    task automatic test_pop_release_same();
        drive_cycle(2'b01, 2'b01, 5, 0);
        n_checks++; if (fl.free_cnt !== 7'd3) begin n_err++; $display("FAIL same_reg_cnt: got %0d expected 3", fl.free_cnt); end
        n_checks++; if (fl.err !== 3'b101) begin n_err++; $display("FAIL same_reg_err: got %b expected 101", fl.err); end
        drive_cycle(2'b11, 2'b00, 0, 0);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_err++; $display("FAIL same_reg_sb: got %0d expected %0d", g, e); end
        end
        n_checks++; if (fl.free_cnt !== 7'd1 || fl.alloc_preg[0] !== 6'd5) begin
            n_err++; $display("FAIL same_reg_tail: got cnt %0d peek %0d expected cnt 1 peek 5", fl.free_cnt, fl.alloc_preg[0]);
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 70; c++) begin
            int r = (c * 37 + 3) % NPREG;
            drive_cycle(2'b01, 2'b01, r, 0);
            n_checks++; if (fl.free_cnt !== 7'd1) begin n_err++; $display("FAIL wrap_cnt[%0d]: got %0d expected 1", c, fl.free_cnt); end
            n_checks++; if (int'(fl.alloc_preg[0]) !== r) begin n_err++; $display("FAIL wrap_peek[%0d]: got %0d expected %0d", c, fl.alloc_preg[0], r); end
        end
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_err++; $display("FAIL wrap_sb: got %0d expected %0d", g, e); end
        end
        n_checks++; if (fl.err !== merr) begin n_err++; $display("FAIL wrap_err: got %b expected %b", fl.err, merr); end
    endtask

    task automatic test_async_reset();
        fl.alloc_en    = 2'b11;
        fl.rel_en      = 2'b11;
        fl.rel_preg[0] = 6'd1;
        fl.rel_preg[1] = 6'd2;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (fl.free_cnt !== 7'd48) begin n_err++; $display("FAIL async_cnt: got %0d expected 48", fl.free_cnt); end
        n_checks++; if (fl.alloc_rdy !== 2'b11) begin n_err++; $display("FAIL async_rdy: got %b expected 11", fl.alloc_rdy); end
        n_checks++; if (fl.alloc_preg[0] !== 6'd16 || fl.alloc_preg[1] !== 6'd17) begin
            n_err++; $display("FAIL async_peek: got {%0d,%0d} expected {17,16}", fl.alloc_preg[1], fl.alloc_preg[0]);
        end
        n_checks++; if (fl.err !== 3'b000) begin n_err++; $display("FAIL async_err: got %b expected 000", fl.err); end
        @(posedge clk);
        #1;
        fl.alloc_en = 2'b00;
        fl.rel_en   = 2'b00;
        rst         = 1'b0;
        model_reset();
        drive_cycle(2'b11, 2'b00, 0, 0);
        while (exp_q.size() > 0) begin
            int e = exp_q.pop_front();
            int g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_err++; $display("FAIL post_reset_sb: got %0d expected %0d", g, e); end
        end
        n_checks++; if (fl.free_cnt !== 7'd46) begin n_err++; $display("FAIL post_reset_cnt: got %0d expected 46", fl.free_cnt); end
    endtask

    initial begin
        fl.alloc_en    = 2'b00;
        fl.rel_en      = 2'b00;
        fl.rel_preg[0] = '0;
        fl.rel_preg[1] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_alloc_pair();
        test_drain();
        test_release_empty();
        test_double_free();
        test_pop_release_same();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
